// File: rtl/sram_stream_reader_if.sv
// Bus bundle for sram_stream_reader: control (start/busy/done), the
// Avalon-MM read port towards the SRAM, and the outgoing valid/ready stream.
//
// Handshake: a stream word transfers on a rising clk edge where
// st_valid & st_ready are both 1. Once raised, st_valid and st_data stay
// stable until that transfer happens. st_ready may change freely. The SRAM
// read uses no handshake: each cycle with chipselect=1 is one read, and
// readdata is valid exactly one cycle later.
interface sram_stream_reader_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;

    // The reader's own view of the bundle.
    modport master (
        input  start, base_addr, length, readdata, st_ready,
        output busy, done, address, chipselect, write, byteenable,
        output st_data, st_valid
    );

    // The environment's view: controller, SRAM port and stream sink.
    modport slave (
        output start, base_addr, length, readdata, st_ready,
        input  busy, done, address, chipselect, write, byteenable,
        input  st_data, st_valid
    );
endinterface

// File: rtl/sram_stream_reader.sv
// Drains a contiguous block of SRAM words into a valid/ready stream.
// Reads issue at up to one per cycle. A small show-ahead FIFO absorbs the
// one-cycle read latency. Issue is gated by a credit check
// (fifo_count + inflight < FIFO_DEPTH), so every returning word has a slot.
module sram_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sram_stream_reader_if.master bus,
    output logic [1:0]           dbg_state
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W:0]   issue_left_q;
    logic [ADDR_W:0]   recv_left_q;
    logic              inflight_q;
    logic              done_q;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic issue;
    logic push;
    logic pop;
    logic credit_ok;
    logic accept_start;
    logic zero_start;
    logic last_pop;

    // Next-state and per-cycle strobes. The credit check counts the read
    // still in flight, because its word lands in the FIFO next cycle.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        accept_start = 1'b0;
        zero_start   = 1'b0;
        push         = inflight_q;
        pop          = (count_q != '0) && bus.st_ready;
        last_pop     = pop && (recv_left_q == (ADDR_W+1)'(1));
        credit_ok    = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < DEPTH_C;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.length != '0) begin
                        accept_start = 1'b1;
                        state_d      = S_RUN;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if ((issue_left_q != '0) && credit_ok) begin
                    issue = 1'b1;
                    if (issue_left_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address pointer and the issue/receive countdowns. Addresses wrap
    // naturally at 2^ADDR_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            last_addr_q  <= '0;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= zero_start || last_pop;
            if (accept_start) begin
                addr_q       <= bus.base_addr;
                issue_left_q <= bus.length;
                recv_left_q  <= bus.length;
            end else begin
                if (issue) begin
                    addr_q       <= addr_q + 1'b1;
                    last_addr_q  <= addr_q;
                    issue_left_q <= issue_left_q - 1'b1;
                end
                if (pop) begin
                    recv_left_q <= recv_left_q - 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy. A reset empties the FIFO and drops the
    // read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage. It has no reset because an empty FIFO hides its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.readdata;
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.chipselect = issue;
    assign bus.address    = issue ? addr_q : last_addr_q;
    assign bus.write      = 1'b0;
    assign bus.byteenable = '1;
    assign bus.st_valid   = (count_q != '0);
    assign bus.st_data    = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Self-checking bench for sram_stream_reader. A behavioural SRAM serves reads
// with one cycle of latency. A scoreboard queue holds the words each start
// must produce.
module tb_sram_stream_reader;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic       clk;
    logic       reset_n;
    logic [1:0] dbg_state;

    sram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] mem [0:65535];

    always @(posedge clk) begin
        bus.readdata <= bus.chipselect ? mem[bus.address] : 32'hDEAD_BEEF;
    end

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    int errors = 0;
    int checks = 0;
    int issued = 0;
    int popped = 0;
    int cs_count = 0;
    int acc_count = 0;
    int done_count = 0;
    bit rdy_rand = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: compares stream words against the queue, checks issued
    // addresses, and checks that no read issues without a free FIFO slot.
    always @(negedge clk) begin
        if (!reset_n) begin
            issued = 0;
            popped = 0;
        end else begin
            if (bus.chipselect) begin
                check_val("credit", 32'((issued - popped) < 4), 32'd1);
                check_val("addr", 32'(bus.address), 32'(exp_addr));
                check_val("cs_busy", 32'(bus.busy), 32'd1);
                exp_addr = exp_addr + 1'b1;
                issued++;
                cs_count++;
            end
            if (bus.st_valid && bus.st_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_val("stream", bus.st_data, exp_q.pop_front());
                end
                popped++;
                acc_count++;
            end
            if (bus.done) done_count++;
        end
    end

    // Random back-pressure driver (~30% low).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) bus.st_ready = ($urandom_range(0, 99) >= 30);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.length    = len;
        exp_addr      = base;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(mem[ADDR_W'(base + ADDR_W'(i))]);
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < max_cycles) begin
            @(negedge clk);
            if (bus.done) seen = 1;
            n++;
        end
        if (!seen) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_counts();
        @(posedge clk);
        #1;
        cs_count   = 0;
        acc_count  = 0;
        done_count = 0;
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v;
        for (int i = 0; i < 65536; i++) begin
            v = 32'(i);
            mem[i] = {v[15:0] ^ 16'h5A5A, ~v[15:0]};
        end
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 32'hA0 + 32'(i);

        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.length    = '0;
        bus.st_ready  = 1'b0;
        exp_addr      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done), 32'd0);
        check_val("rst_cs", 32'(bus.chipselect), 32'd0);
        check_val("rst_addr", 32'(bus.address), 32'd0);
        check_val("rst_valid", 32'(bus.st_valid), 32'd0);
        check_val("rst_data", bus.st_data, 32'd0);
        check_val("rst_write", 32'(bus.write), 32'd0);
        check_val("rst_be", 32'(bus.byteenable), 32'hF);
        check_val("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;

        // Basic: 8 words with cycle-exact valid and done timing.
        bus.st_ready = 1'b1;
        clear_counts();
        do_start(16'h0100, 17'd8);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check_val("basic_busy", 32'(bus.busy), 32'(c <= 10));
            check_val("basic_valid", 32'(bus.st_valid), 32'(c >= 3 && c <= 10));
            check_val("basic_done", 32'(bus.done), 32'(c == 11));
        end
        check_val("basic_cs_count", 32'(cs_count), 32'd8);
        check_val("basic_sb_left", 32'(exp_q.size()), 32'd0);

        // Zero length: done one cycle after start, nothing else moves.
        clear_counts();
        do_start(16'h0050, 17'd0);
        @(negedge clk);
        check_val("zero_done", 32'(bus.done), 32'd1);
        check_val("zero_busy", 32'(bus.busy), 32'd0);
        check_val("zero_cs", 32'(bus.chipselect), 32'd0);
        check_val("zero_valid", 32'(bus.st_valid), 32'd0);
        @(negedge clk);
        check_val("zero_done_width", 32'(bus.done), 32'd0);
        check_val("zero_busy2", 32'(bus.busy), 32'd0);
        check_val("zero_cs_count", 32'(cs_count), 32'd0);

        // Back-pressure: 16 words, random st_ready.
        clear_counts();
        rdy_rand = 1;
        do_start(16'h1000, 17'd16);
        wait_done(600);
        rdy_rand = 0;
        bus.st_ready = 1'b1;
        check_val("bp_sb_left", 32'(exp_q.size()), 32'd0);
        check_val("bp_cs_count", 32'(cs_count), 32'd16);
        check_val("bp_acc_count", 32'(acc_count), 32'd16);

        // Address wrap at the top of the address space.
        clear_counts();
        do_start(16'hFFFE, 17'd4);
        wait_done(100);
        check_val("wrap_sb_left", 32'(exp_q.size()), 32'd0);
        check_val("wrap_cs_count", 32'(cs_count), 32'd4);
        check_val("wrap_last_addr", 32'(bus.address), 32'h0001);

        // Reset in the middle of a long transfer.
        clear_counts();
        do_start(16'h2000, 17'd32);
        for (int n = 0; n < 200 && acc_count < 5; n++) begin
            @(posedge clk);
            #1;
        end
        check_val("mid_acc_reached", 32'(acc_count >= 5), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_val("mid_rst_cs", 32'(bus.chipselect), 32'd0);
        check_val("mid_rst_addr", 32'(bus.address), 32'd0);
        check_val("mid_rst_valid", 32'(bus.st_valid), 32'd0);
        check_val("mid_rst_data", bus.st_data, 32'd0);
        check_val("mid_rst_state", 32'(dbg_state), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_counts();
        do_start(16'h0200, 17'd2);
        wait_done(100);
        repeat (3) @(negedge clk);
        check_val("post_rst_sb_left", 32'(exp_q.size()), 32'd0);
        check_val("post_rst_acc", 32'(acc_count), 32'd2);

        // Start while busy must be ignored.
        clear_counts();
        do_start(16'h0100, 17'd8);
        repeat (2) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = 16'h0300;
        bus.length    = 17'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(100);
        repeat (10) @(negedge clk);
        check_val("busy_start_done_cnt", 32'(done_count), 32'd1);
        check_val("busy_start_acc", 32'(acc_count), 32'd8);
        check_val("busy_start_cs", 32'(cs_count), 32'd8);
        check_val("busy_start_sb_left", 32'(exp_q.size()), 32'd0);
        check_val("busy_start_idle", 32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_stream_reader.md
# sram_stream_reader

Avalon-MM read initiator that drains a contiguous block of words from one port of the dual-port on-chip SRAM and presents them as a valid/ready stream, e.g. audio frames staged in SRAM feeding a feature-extraction pipeline. It issues single-word reads at up to one per cycle, absorbs the SRAM's fixed one-cycle read latency in a small output FIFO, and throttles issue with a credit count so that no returning word is ever dropped under downstream back-pressure.

## Interface
- ADDR_W, 16, word-address width; matches SRAM port address width.
- DATA_W, 32, word width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, ≥2.

- clk  in  1  sole clock; the SRAM port runs on the same clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; samples base_addr and length when idle.
- base_addr  in  ADDR_W  first word address.
- length  in  ADDR_W+1  word count, 0..2^ADDR_W.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- address  out  ADDR_W  SRAM word address.
- chipselect  out  1  read strobe; one word per asserted cycle.
- write  out  1  constant 0.
- byteenable  out  DATA_W/8  constant all-ones.
- readdata  in  DATA_W  SRAM data; valid exactly 1 cycle after chipselect.
- st_data  out  DATA_W  stream word (FIFO head, show-ahead).
- st_valid  out  1  st_data valid.
- st_ready  in  1  downstream accept; a word transfers when st_valid & st_ready.

## Operation
- States: IDLE, RUN (issuing reads), DRAIN (all reads issued, words outstanding).
- IDLE: start=1 and length≠0 → latch addr=base_addr, issue_left=length, recv_left=length; go to RUN. start=1 and length=0 → done pulses next cycle, busy stays 0, state stays IDLE.
- RUN: issue when issue_left≠0 and fifo_count + inflight < FIFO_DEPTH. inflight is a 1-bit flag that equals the previous cycle's chipselect. On issue: address=addr, chipselect=1, then addr+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), issue_left−1. Go to DRAIN when the final read issues.
- Every cycle with inflight=1, readdata is pushed into the FIFO. The credit rule guarantees that the FIFO is never full at push time.
- Pop on st_valid & st_ready, then recv_left−1. Push and pop in the same cycle leave fifo_count unchanged.
- DRAIN: the pop that drives recv_left to 0 causes done=1 in the next cycle, busy=0 in that same cycle, and a return to IDLE.
- start while busy: ignored, with no effect on the running transfer.
- Reset mid-transfer: FIFO emptied, in-flight read discarded, counters cleared, state IDLE. Upstream restarts.
- chipselect=0 in every cycle other than an issue cycle. address holds its last value when idle.

## Timing
- Reset values: busy=0, done=0, chipselect=0, address=0, st_valid=0, st_data=0, write=0, byteenable=all-ones.
- start at cycle 0 → busy=1 and first chipselect at cycle 1 → readdata sampled at cycle 2 → st_valid=1 with st_data=mem[base_addr] at cycle 3.
- With st_ready held high, throughput is 1 word/cycle after fill. An N-word transfer shows st_valid high for cycles 3..N+2, and done pulses at cycle N+3.
- With st_ready low, at most FIFO_DEPTH reads are outstanding or buffered. chipselect stops within 1 cycle of the FIFO filling and resumes the cycle after a pop frees a credit.
- done is exactly 1 cycle wide. A new start is accepted in the done cycle, because state is IDLE then.

## Test plan
- Basic: mem[0x0100..0x0107]=0xA0..0xA7, start base=0x0100 len=8, st_ready=1 → stream A0..A7 in order on cycles 3..10; done at cycle 11; 8 chipselects total.
- Back-pressure: len=16, st_ready toggles randomly (~30% low) → all 16 words in order, none dropped or duplicated; fifo_count never exceeds 4; chipselect is never asserted when fifo_count + inflight = 4.
- Wrap: base=0xFFFE len=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 issued; data stream matches.
- Zero length: start len=0 → done at cycle 1; busy, chipselect, and st_valid stay 0.
- Reset mid-op: len=32, deassert reset_n after 5 words accepted → all outputs at reset values asynchronously. After release, a new start base=0x0200 len=2 yields exactly mem[0x0200], mem[0x0201] with no stale words.
- Start while busy: second start with base=0x0300 len=4 during a len=8 transfer → ignored; exactly the 8 original words are streamed, with a single done pulse.
